// File: rtl/alu_cpu_pkg.sv
// Shared definitions for the aluCPU arbiter: FSM encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_cpu_pkg;

    localparam int DW_DEF      = 16;
    localparam int OPW_DEF     = 3;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the one not granted last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; contention resolved against the last-served requester
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/alu_cpu_arbiter.sv
// Shares one aluCPU between two requesters, round-robin, one transaction in flight at a time.
// Latency: accept in IDLE, rsp_valid at least 4 cycles later (ISSUE, >=2 WAIT, RESP).
// Backpressure: requesters hold req_valid until req_accept; nothing accepted while CPU busy or a job is in flight.
module alu_cpu_arbiter
    import alu_cpu_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    input  logic [DW-1:0]  req_data0,
    input  logic [DW-1:0]  req_data1,
    output logic [1:0]     req_accept,
    output logic [1:0]     rsp_valid,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    output logic [OPW-1:0] cpu_instruction,
    output logic [DW-1:0]  cpu_data,
    output logic           cpu_new_instruction,
    input  logic           cpu_ready,
    input  logic [DW-1:0]  cpu_data_out
);

    // Counter must hold both TIMEOUT and the fixed "2" fast-completion point
    localparam int CW = ($clog2(TIMEOUT + 1) < 2) ? 2 : $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_gnt;
    logic [CW-1:0]   r_cnt;
    logic            r_seen_busy;
    logic [OPW-1:0]  r_op;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_result;
    logic            r_err;

    logic [1:0]      w_grant;
    logic            w_take;
    logic            w_done;
    logic            w_tout;

    rr_arb2 u_rr_arb2 (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_take = cpu_ready && (req_valid != 2'b00);
    // A CPU that never drops ready is treated as done on the second WAIT cycle
    assign w_done = cpu_ready && (r_seen_busy || (r_cnt == CW'(2)));
    assign w_tout = (r_cnt >= CW'(TIMEOUT));

    // State register plus the latched request, wait bookkeeping and result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b0;
            r_gnt       <= 1'b0;
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_op        <= '0;
            r_data      <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_gnt  <= w_grant[1];
                        r_op   <= w_grant[1] ? req_op1 : req_op0;
                        r_data <= w_grant[1] ? req_data1 : req_data0;
                    end
                end
                S_ISSUE: begin
                    r_cnt       <= CW'(1);
                    r_seen_busy <= 1'b0;
                end
                S_WAIT: begin
                    if (!cpu_ready) begin
                        r_seen_busy <= 1'b1;
                    end
                    // Completion has priority over a coincident timeout
                    if (w_done) begin
                        r_result <= cpu_data_out;
                        r_err    <= 1'b0;
                    end else if (w_tout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_last <= r_gnt;
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode; every output is held low while reset is asserted
    always_comb begin
        w_next              = r_state;
        req_accept          = 2'b00;
        rsp_valid           = 2'b00;
        rsp_data            = '0;
        rsp_err             = 1'b0;
        cpu_new_instruction = 1'b0;
        cpu_instruction     = '0;
        cpu_data            = '0;
        if (!rst) begin
            cpu_instruction = r_op;
            cpu_data        = r_data;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        req_accept = w_grant;
                        w_next     = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cpu_new_instruction = 1'b1;
                    w_next              = S_WAIT;
                end
                S_WAIT: begin
                    if (w_done || w_tout) begin
                        w_next = S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid = r_gnt ? 2'b10 : 2'b01;
                    rsp_data  = r_result;
                    rsp_err   = r_err;
                    w_next    = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

endmodule
